// File: rtl/ppc_types.sv
// Shared types for the PowerPC dispatch path: flag bit positions inside the
// writeback flag bundle, the execution-unit enumeration and its index mapping.
// Optional build feature: DISPATCH_PERF_COUNTERS_EN (see dispatch_queue).
package ppc_types;

  // Flag bundle layout {gpr, spr, cr, alter_xer, alter_cr0, read_xer}, MSB first
  localparam int DISPATCH_FLAG_GPR      = 5;
  localparam int DISPATCH_FLAG_SPR      = 4;
  localparam int DISPATCH_FLAG_CR       = 3;
  localparam int DISPATCH_FLAG_XER      = 2;
  localparam int DISPATCH_FLAG_CR0      = 1;
  localparam int DISPATCH_FLAG_READ_XER = 0;
  localparam int DISPATCH_FLAG_COUNT    = 6;

  typedef enum logic [3:0] {
    EU_FXU0   = 4'd0,
    EU_FXU1   = 4'd1,
    EU_MUL    = 4'd2,
    EU_DIV    = 4'd3,
    EU_BRANCH = 4'd4,
    EU_CR     = 4'd5,
    EU_LSU    = 4'd6,
    EU_SPR    = 4'd7,
    EU_FPU    = 4'd8
  } execute_unit_t;

  // Channel index of an execution unit on the dispatch_queue unit ports
  function automatic int unsigned unit_index(execute_unit_t u);
    return int'(u);
  endfunction

endpackage

// File: rtl/dispatch_fifo.sv
// Generic DEPTH x WIDTH circular buffer with push, pop, synchronous flush and
// an entry count. Storage is not reset; only pointers and count are.
module dispatch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Next pointers and count; power-of-two DEPTH makes the pointers wrap naturally
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
    else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  // Pointer and count registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage, written at the tail
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/dispatch_queue.sv
// In-order dispatch queue: buffers decoded instructions and issues the head to
// one of NUM_UNITS execution units with a valid/ready handshake, returning the
// accepting unit's reservation-station ID and the writeback flags registered.
// Optional build feature: define DISPATCH_PERF_COUNTERS_EN to add the
// perf_issue_count / perf_stall_count outputs.
module dispatch_queue
  import ppc_types::*;
#(
  parameter int RS_ID_WIDTH    = 5,
  parameter int NUM_UNITS      = 9,
  parameter int DEPTH          = 4,
  parameter int PAYLOAD_WIDTH  = 64,
  parameter int FLAG_WIDTH     = DISPATCH_FLAG_COUNT,
  parameter int UNIT_SEL_WIDTH = $clog2(NUM_UNITS + 1),
  localparam int OCC_W         = $clog2(DEPTH + 1)
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             flush,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [UNIT_SEL_WIDTH-1:0]        in_unit,
  input  logic [PAYLOAD_WIDTH-1:0]         in_payload,
  input  logic [FLAG_WIDTH-1:0]            in_flags,
  output logic [NUM_UNITS-1:0]             unit_valid,
  input  logic [NUM_UNITS-1:0]             unit_ready,
  output logic [PAYLOAD_WIDTH-1:0]         unit_payload,
  input  logic [NUM_UNITS*RS_ID_WIDTH-1:0] unit_id,
  output logic                             dispatched,
  output logic [RS_ID_WIDTH-1:0]           id_taken,
  output logic [FLAG_WIDTH-1:0]            flags_out,
  output logic                             invalid_instr,
`ifdef DISPATCH_PERF_COUNTERS_EN
  output logic [31:0]                      perf_issue_count,
  output logic [31:0]                      perf_stall_count,
`endif
  output logic [OCC_W-1:0]                 occupancy
);

  localparam int ENTRY_W = UNIT_SEL_WIDTH + FLAG_WIDTH + PAYLOAD_WIDTH;

  logic [ENTRY_W-1:0]        head_entry;
  logic [UNIT_SEL_WIDTH-1:0] head_unit;
  logic [FLAG_WIDTH-1:0]     head_flags;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      head_live;
  logic                      head_invalid;
  logic                      fire;
  logic                      drop;
  logic                      push;
  logic [RS_ID_WIDTH-1:0]    sel_id;

  logic                      dispatched_q;
  logic                      invalid_q;
  logic [RS_ID_WIDTH-1:0]    id_taken_q;
  logic [FLAG_WIDTH-1:0]     flags_q;

  // No pass-through when full: in_ready depends only on the stored count
  assign in_ready     = ~fifo_full;
  assign push         = in_valid & in_ready & ~flush;
  assign head_unit    = head_entry[ENTRY_W-1 -: UNIT_SEL_WIDTH];
  assign head_flags   = head_entry[PAYLOAD_WIDTH +: FLAG_WIDTH];
  assign unit_payload = head_entry[PAYLOAD_WIDTH-1:0];
  assign head_live    = ~fifo_empty & ~flush;
  assign head_invalid = (head_unit >= UNIT_SEL_WIDTH'(NUM_UNITS));
  assign fire         = |(unit_valid & unit_ready);
  // Entries with an out-of-range unit select are dropped without a handshake
  assign drop         = head_live & head_invalid;

  dispatch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .flush (flush),
    .push  (push),
    .pop   (fire | drop),
    .wdata ({in_unit, in_flags, in_payload}),
    .rdata (head_entry),
    .count (occupancy),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Decode the head unit select into the one-hot valid and pick that unit's ID
  always_comb begin
    unit_valid = '0;
    sel_id     = '0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      if (head_unit == UNIT_SEL_WIDTH'(k)) begin
        unit_valid[k] = head_live;
        sel_id        = unit_id[k*RS_ID_WIDTH +: RS_ID_WIDTH];
      end
    end
  end

  // Issue result registers: pulses follow each pop, ID/flags hold the last issue
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dispatched_q <= 1'b0;
      invalid_q    <= 1'b0;
      id_taken_q   <= '0;
      flags_q      <= '0;
    end else begin
      dispatched_q <= fire;
      invalid_q    <= drop;
      if (fire) begin
        id_taken_q <= sel_id;
        flags_q    <= head_flags;
      end
    end
  end

  assign dispatched    = dispatched_q;
  assign invalid_instr = invalid_q;
  assign id_taken      = id_taken_q;
  assign flags_out     = flags_q;

`ifdef DISPATCH_PERF_COUNTERS_EN
  logic [31:0] issue_cnt_q;
  logic [31:0] stall_cnt_q;
  logic        stall;

  assign stall = |(unit_valid & ~unit_ready);

  // Free-running issue and stall counters, wrapping at 2^32
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      issue_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (fire)  issue_cnt_q <= issue_cnt_q + 32'd1;
      if (stall) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign perf_issue_count = issue_cnt_q;
  assign perf_stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_dispatch_queue.sv
// Self-checking bench for dispatch_queue: scoreboard of expected issue results
// filled as entries are pushed and drained as dispatched pulses appear.
module tb_dispatch_queue;

  localparam int RSW = 5;
  localparam int NU  = 9;
  localparam int PW  = 64;
  localparam int FW  = 6;
  localparam int SW  = 4;

  typedef struct packed {
    logic [RSW-1:0] id;
    logic [FW-1:0]  flags;
  } exp_t;

  logic              clk = 1'b0;
  logic              rstn;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [SW-1:0]     in_unit;
  logic [PW-1:0]     in_payload;
  logic [FW-1:0]     in_flags;
  logic [NU-1:0]     unit_valid;
  logic [NU-1:0]     unit_ready;
  logic [PW-1:0]     unit_payload;
  logic [NU*RSW-1:0] unit_id;
  logic              dispatched;
  logic [RSW-1:0]    id_taken;
  logic [FW-1:0]     flags_out;
  logic              invalid_instr;
  logic [2:0]        occupancy;
`ifdef DISPATCH_PERF_COUNTERS_EN
  logic [31:0]       perf_issue_count;
  logic [31:0]       perf_stall_count;
`endif

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  dispatch_queue dut (
    .clk           (clk),
    .rstn          (rstn),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_unit       (in_unit),
    .in_payload    (in_payload),
    .in_flags      (in_flags),
    .unit_valid    (unit_valid),
    .unit_ready    (unit_ready),
    .unit_payload  (unit_payload),
    .unit_id       (unit_id),
    .dispatched    (dispatched),
    .id_taken      (id_taken),
    .flags_out     (flags_out),
    .invalid_instr (invalid_instr),
`ifdef DISPATCH_PERF_COUNTERS_EN
    .perf_issue_count (perf_issue_count),
    .perf_stall_count (perf_stall_count),
`endif
    .occupancy     (occupancy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference ID of unit k, as wired onto unit_id
  function automatic logic [RSW-1:0] id_of(int k);
    return RSW'((k * 3 + 1) % 32);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_push(int unit, logic [FW-1:0] fl, logic [PW-1:0] pl);
    in_valid   = 1'b1;
    in_unit    = SW'(unit);
    in_flags   = fl;
    in_payload = pl;
  endtask

  task automatic test_reset();
    rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; in_unit = '0;
    in_payload = '0; in_flags = '0; unit_ready = '1;
    for (int k = 0; k < NU; k++) unit_id[k*RSW +: RSW] = id_of(k);
    #12;
    n_chk++;
    if ({dispatched, invalid_instr, id_taken, flags_out} !== '0 || occupancy !== 3'd0 ||
        unit_valid !== '0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset: disp=%b inv=%b id=%0d fl=%b occ=%0d uv=%b rdy=%b required all 0, rdy=1",
               dispatched, invalid_instr, id_taken, flags_out, occupancy, unit_valid, in_ready);
    end
    #3 rstn = 1'b1;
    tick();
  endtask

  task automatic test_single();
    exp_t e;
    drive_push(2, 6'b100000, 64'hA5A5_0000_0000_0002);
    sb.push_back('{id: id_of(2), flags: 6'b100000});
    tick();
    in_valid = 1'b0;
    n_chk++;
    if (unit_valid !== 9'b000000100 || dispatched !== 1'b0) begin
      n_fail++;
      $display("FAIL single_valid: uv=%b disp=%b required 000000100 0", unit_valid, dispatched);
    end
    tick();
    n_chk++;
    if (dispatched !== 1'b1) begin
      n_fail++;
      $display("FAIL single_disp: dispatched=%b required 1", dispatched);
    end else begin
      e = sb.pop_front();
      if (id_taken !== e.id || flags_out !== e.flags) begin
        n_fail++;
        $display("FAIL single_issue: id=%0d fl=%b required id=%0d fl=%b",
                 id_taken, flags_out, e.id, e.flags);
      end
    end
    tick();
    n_chk++;
    if (dispatched !== 1'b0 || occupancy !== 3'd0) begin
      n_fail++;
      $display("FAIL single_after: disp=%b occ=%0d required 0 0", dispatched, occupancy);
    end
  endtask

  task automatic test_full();
    exp_t e;
    int units[4] = '{0, 1, 4, 5};
    unit_ready = '0;
    for (int i = 0; i < 4; i++) begin
      drive_push(units[i], FW'(6'h08 + i), PW'(64'h1000 + i));
      sb.push_back('{id: id_of(units[i]), flags: FW'(6'h08 + i)});
      tick();
    end
    n_chk++;
    if (in_ready !== 1'b0 || occupancy !== 3'd4) begin
      n_fail++;
      $display("FAIL full_state: in_ready=%b occ=%0d required 0 4", in_ready, occupancy);
    end
    drive_push(6, 6'h3F, 64'hDEAD);
    tick();
    in_valid = 1'b0;
    n_chk++;
    if (occupancy !== 3'd4 || dispatched !== 1'b0) begin
      n_fail++;
      $display("FAIL full_fifth: occ=%0d disp=%b required 4 0", occupancy, dispatched);
    end
    unit_ready = '1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_chk++;
      if (dispatched !== 1'b1 || sb.size() == 0) begin
        n_fail++;
        $display("FAIL full_drain%0d: dispatched=%b required 1", i, dispatched);
      end else begin
        e = sb.pop_front();
        if (id_taken !== e.id || flags_out !== e.flags) begin
          n_fail++;
          $display("FAIL full_order%0d: id=%0d fl=%h required id=%0d fl=%h",
                   i, id_taken, flags_out, e.id, e.flags);
        end
      end
    end
    tick();
    n_chk++;
    if (dispatched !== 1'b0 || occupancy !== 3'd0) begin
      n_fail++;
      $display("FAIL full_empty: disp=%b occ=%0d required 0 0 (fifth push leaked?)",
               dispatched, occupancy);
    end
  endtask

  task automatic test_stall();
    exp_t e;
    logic [31:0] base;
    unit_ready = '1;
    unit_ready[3] = 1'b0;
    drive_push(3, 6'b001100, 64'hCAFE_F00D_1234_5678);
    sb.push_back('{id: id_of(3), flags: 6'b001100});
    tick();
    in_valid = 1'b0;
    base = 32'd0;
`ifdef DISPATCH_PERF_COUNTERS_EN
    base = perf_stall_count;
`endif
    for (int i = 0; i < 5; i++) begin
      tick();
      n_chk++;
      if (unit_valid !== 9'b000001000 || unit_payload !== 64'hCAFE_F00D_1234_5678 ||
          dispatched !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold%0d: uv=%b pl=%h disp=%b required 000001000 cafef00d12345678 0",
                 i, unit_valid, unit_payload, dispatched);
      end
    end
`ifdef DISPATCH_PERF_COUNTERS_EN
    n_chk++;
    if (perf_stall_count - base !== 32'd5) begin
      n_fail++;
      $display("FAIL stall_perf: delta=%0d required 5", perf_stall_count - base);
    end
`else
    n_chk++;
    if (base !== 32'd0 || occupancy !== 3'd1) begin
      n_fail++;
      $display("FAIL stall_occ: occ=%0d required 1", occupancy);
    end
`endif
    unit_ready[3] = 1'b1;
    tick();
    n_chk++;
    if (dispatched !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_release: dispatched=%b required 1", dispatched);
    end else begin
      e = sb.pop_front();
      if (id_taken !== e.id || flags_out !== e.flags) begin
        n_fail++;
        $display("FAIL stall_issue: id=%0d fl=%b required id=%0d fl=%b",
                 id_taken, flags_out, e.id, e.flags);
      end
    end
  endtask

  task automatic test_invalid();
    logic [RSW-1:0] id_prev;
    logic [FW-1:0]  fl_prev;
    id_prev = id_taken;
    fl_prev = flags_out;
    drive_push(15, 6'b010101, 64'hBAD);
    tick();
    in_valid = 1'b0;
    n_chk++;
    if (unit_valid !== '0 || occupancy !== 3'd1) begin
      n_fail++;
      $display("FAIL invalid_head: uv=%b occ=%0d required 0 1", unit_valid, occupancy);
    end
    tick();
    n_chk++;
    if (invalid_instr !== 1'b1 || dispatched !== 1'b0 || occupancy !== 3'd0 ||
        id_taken !== id_prev || flags_out !== fl_prev) begin
      n_fail++;
      $display("FAIL invalid_pulse: inv=%b disp=%b occ=%0d id=%0d fl=%b required 1 0 0 %0d %b",
               invalid_instr, dispatched, occupancy, id_taken, flags_out, id_prev, fl_prev);
    end
    tick();
    n_chk++;
    if (invalid_instr !== 1'b0) begin
      n_fail++;
      $display("FAIL invalid_clear: invalid_instr=%b required 0", invalid_instr);
    end
  endtask

  task automatic test_flush();
    unit_ready = '0;
    for (int i = 0; i < 3; i++) begin
      drive_push(i + 1, FW'(i), PW'(64'h2000 + i));
      tick();
    end
    drive_push(7, 6'h2A, 64'h3000);
    flush = 1'b1;
    unit_ready = '1;
    #1;
    n_chk++;
    if (unit_valid !== '0) begin
      n_fail++;
      $display("FAIL flush_valid: uv=%b required 0", unit_valid);
    end
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    n_chk++;
    if (occupancy !== 3'd0 || dispatched !== 1'b0 || invalid_instr !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_state: occ=%0d disp=%b inv=%b rdy=%b required 0 0 0 1",
               occupancy, dispatched, invalid_instr, in_ready);
    end
    tick();
    n_chk++;
    if (dispatched !== 1'b0 || unit_valid !== '0) begin
      n_fail++;
      $display("FAIL flush_discard: disp=%b uv=%b required 0 0", dispatched, unit_valid);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    unit_ready = '1;
    for (int i = 0; i <= 10; i++) begin
      if (i < 10) begin
        drive_push(i % NU, FW'(i + 1), PW'(64'h4000 + i));
        sb.push_back('{id: id_of(i % NU), flags: FW'(i + 1)});
      end else begin
        in_valid = 1'b0;
      end
      tick();
      n_chk++;
      if ((i < 10 && occupancy !== 3'd1) || (i == 10 && occupancy !== 3'd0)) begin
        n_fail++;
        $display("FAIL b2b_occ%0d: occ=%0d required %0d", i, occupancy, (i < 10) ? 1 : 0);
      end
      if (i > 0) begin
        n_chk++;
        if (dispatched !== 1'b1 || sb.size() == 0) begin
          n_fail++;
          $display("FAIL b2b_disp%0d: dispatched=%b required 1", i, dispatched);
        end else begin
          e = sb.pop_front();
          if (id_taken !== e.id || flags_out !== e.flags) begin
            n_fail++;
            $display("FAIL b2b_order%0d: id=%0d fl=%h required id=%0d fl=%h",
                     i, id_taken, flags_out, e.id, e.flags);
          end
        end
      end
    end
    // Second stream, cut by an asynchronous reset mid-cycle
    drive_push(4, 6'h11, 64'h5000);
    tick();
    drive_push(5, 6'h12, 64'h5001);
    tick();
    #2 rstn = 1'b0;
    in_valid = 1'b0;
    #1;
    n_chk++;
    if ({dispatched, invalid_instr, id_taken, flags_out} !== '0 || occupancy !== 3'd0 ||
        unit_valid !== '0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset: disp=%b inv=%b id=%0d fl=%b occ=%0d uv=%b rdy=%b required all 0, rdy=1",
               dispatched, invalid_instr, id_taken, flags_out, occupancy, unit_valid, in_ready);
    end
    sb.delete();
    #1 rstn = 1'b1;
    tick();
    drive_push(1, 6'h15, 64'h6000);
    sb.push_back('{id: id_of(1), flags: 6'h15});
    tick();
    in_valid = 1'b0;
    n_chk++;
    if (occupancy !== 3'd1 || unit_valid !== 9'b000000010) begin
      n_fail++;
      $display("FAIL postreset_push: occ=%0d uv=%b required 1 000000010", occupancy, unit_valid);
    end
    tick();
    n_chk++;
    if (dispatched !== 1'b1) begin
      n_fail++;
      $display("FAIL postreset_disp: dispatched=%b required 1", dispatched);
    end else begin
      e = sb.pop_front();
      if (id_taken !== e.id || flags_out !== e.flags) begin
        n_fail++;
        $display("FAIL postreset_issue: id=%0d fl=%h required id=%0d fl=%h",
                 id_taken, flags_out, e.id, e.flags);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_stall();
    test_invalid();
    test_flush();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
